alu_result_framer: RTL



---
 rtl/alu_framer_pkg.sv | 16 +
 rtl/alu_result_framer_if.sv | 22 ++
 rtl/alu_result_fifo.sv | 54 +++++
 rtl/alu_result_framer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_framer_pkg.sv
// rtl/alu_framer_pkg.sv - shared state enum, byte constants and index sizing for the ALU result framer
package alu_framer_pkg;

    typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;

    localparam int BYTE_W        = 8;
    localparam int OUT_WIDTH_DEF = 16;
    localparam int N_DEF         = OUT_WIDTH_DEF / BYTE_W;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(N_DEF);

endpackage

// File: rtl/alu_result_framer_if.sv
// rtl/alu_result_framer_if.sv - ALU result input, TX byte stream and status signals of the framer
interface alu_result_framer_if #(
    parameter int Out_Width = 16
);
    logic [Out_Width-1:0] ALU_OUT;
    logic                 OUT_VALID;
    logic [7:0]           TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;
    logic                 OVERFLOW;
    logic                 BUSY;

    modport master (
        output ALU_OUT, OUT_VALID, TX_READY,
        input  TX_DATA, TX_VALID, OVERFLOW, BUSY
    );

    modport slave (
        input  ALU_OUT, OUT_VALID, TX_READY,
        output TX_DATA, TX_VALID, OVERFLOW, BUSY
    );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - show-ahead synchronous result FIFO; full/empty come from the registered count
module alu_result_fifo
    import alu_framer_pkg::*;
#(
    parameter int Out_Width  = 16,
    parameter int Fifo_Depth = 4,
    localparam int PTR_W     = $clog2(Fifo_Depth),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 push,
    input  logic [Out_Width-1:0] wdata,
    input  logic                 pop,
    output logic [Out_Width-1:0] rdata,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count
);

    logic [Out_Width-1:0] mem [Fifo_Depth];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CNT_W'(Fifo_Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_framer.sv
// rtl/alu_result_framer.sv - buffers ALU results and streams them LSB byte first; ALU_FRAMER_CHKSUM_EN appends an XOR byte
module alu_result_framer
    import alu_framer_pkg::*;
#(
    parameter int Out_Width  = 16,
    parameter int Fifo_Depth = 4
) (
    input  logic              CLK,
    input  logic              RST,
    alu_result_framer_if.slave bus
);

    localparam int N     = Out_Width / BYTE_W;
    localparam int IDX_W = idx_width(N);
    localparam int CNT_W = $clog2(Fifo_Depth) + 1;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [Out_Width-1:0] shreg, shreg_n, shifted;
    logic [BYTE_W-1:0]    tx_data, tx_data_n;
    logic                 tx_valid, tx_valid_n;
    logic                 overflow;
    logic [BYTE_W-1:0]    chk, chk_n;
    logic                 hs, frame_done, load, pop;
    logic [Out_Width-1:0] head;
    logic                 full, empty;
    logic [CNT_W-1:0]     count;

    alu_result_fifo #(.Out_Width(Out_Width), .Fifo_Depth(Fifo_Depth)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (bus.OUT_VALID),
        .wdata (bus.ALU_OUT),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign hs      = tx_valid && bus.TX_READY;
    assign shifted = shreg >> BYTE_W;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        shreg_n    = shreg;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        chk_n      = chk;
        frame_done = 1'b0;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: load = !empty;
            SEND: begin
                if (hs) begin
                    if (idx != IDX_W'(N - 1)) begin
                        idx_n     = idx + 1'b1;
                        shreg_n   = shifted;
                        tx_data_n = shifted[BYTE_W-1:0];
                        chk_n     = chk ^ shifted[BYTE_W-1:0];
                    end else begin
`ifdef ALU_FRAMER_CHKSUM_EN
                        state_n   = CHK;
                        tx_data_n = chk;
`else
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef ALU_FRAMER_CHKSUM_EN
            CHK: frame_done = hs;
`endif
            default: state_n = IDLE;
        endcase
        // A finished frame chains straight into the next word to avoid a bubble.
        if (frame_done) begin
            if (!empty) begin
                load = 1'b1;
            end else begin
                tx_valid_n = 1'b0;
                state_n    = IDLE;
            end
        end
        if (load) begin
            pop        = 1'b1;
            shreg_n    = head;
            tx_data_n  = head[BYTE_W-1:0];
            chk_n      = head[BYTE_W-1:0];
            tx_valid_n = 1'b1;
            idx_n      = '0;
            state_n    = SEND;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            idx      <= '0;
            shreg    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            chk      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            chk      <= chk_n;
            overflow <= bus.OUT_VALID && full;
        end
    end

    assign bus.TX_DATA  = tx_data;
    assign bus.TX_VALID = tx_valid;
    assign bus.OVERFLOW = overflow;
    assign bus.BUSY     = (count != '0) || (state != IDLE);

endmodule
